// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
//   Wishbone-mapped controller for the bidirectional GPIO pad ring. Holds the
//   per-pin output value and direction, synchronises the pad inputs, and
//   raises a maskable, edge-triggered level interrupt.
//
//   Register map (byte address, bits [4:2] select the word):
//     0x00 OUT      RW    pad drive value
//     0x04 DIR      RW    1 = output (pad OEN driven low)
//     0x08 IN       RO    synchronised pad value
//     0x0C IRQ_EN   RW    per-pin interrupt enable
//     0x10 IRQ_PEND RW1C  per-pin pending event
//     0x14 EDGE     RW    1 = rising, 0 = falling
//     0x18/0x1C     unmapped: read 0, writes ignored, still acked
//
//   Ports:
//     clk, reset           single clock, synchronous active-high reset
//     wb_*_i / wb_*_o      Wishbone slave, one ack cycle per accepted request
//     i_gpio               asynchronous pad inputs
//     o_gpio, en_gpio      pad drive value and active-low output enable
//     o_irq                registered interrupt request

module gpio_pad_ctrl #(
    parameter int N_GPIO      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_GPIO-1:0] i_gpio,
    output logic [N_GPIO-1:0] o_gpio,
    output logic [N_GPIO-1:0] en_gpio,
    output logic              o_irq
);

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_IEN  = 3'd3;
    localparam logic [2:0] REG_PEND = 3'd4;
    localparam logic [2:0] REG_EDGE = 3'd5;

    logic [N_GPIO-1:0] out_q,  out_d;
    logic [N_GPIO-1:0] dir_q,  dir_d;
    logic [N_GPIO-1:0] ien_q,  ien_d;
    logic [N_GPIO-1:0] pend_q, pend_d;
    logic [N_GPIO-1:0] edge_q, edge_d;
    logic [N_GPIO-1:0] prev_q;
    logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
    logic              ack_q;
    logic              irq_q;
    logic [31:0]       dat_q,  dat_d;

    logic              req, wr, rd;
    logic [2:0]        reg_sel;
    logic [31:0]       mask32;
    logic [N_GPIO-1:0] wmask, wdata, pin_in, evt, clr;
    logic [31:0]       rd_word;

    // Byte lanes below bit 2 never select a register.
    logic unused_adr;
    assign unused_adr = ^wb_adr_i[1:0];

    always_comb begin
        // The !ack term spaces back-to-back requests one ack apart.
        req     = wb_cyc_i & wb_stb_i & ~ack_q;
        wr      = req & wb_we_i;
        rd      = req & ~wb_we_i;
        reg_sel = wb_adr_i[4:2];

        for (int b = 0; b < 4; b++) begin
            mask32[8*b +: 8] = {8{wb_sel_i[b]}};
        end
        wmask  = mask32[N_GPIO-1:0];
        wdata  = wb_dat_i[N_GPIO-1:0];

        pin_in = sync_q[SYNC_STAGES-1];
        evt    = (edge_q & pin_in & ~prev_q) | (~edge_q & ~pin_in & prev_q);

        out_d  = out_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        edge_d = edge_q;
        clr    = '0;

        if (wr) begin
            case (reg_sel)
                REG_OUT:  out_d  = (out_q  & ~wmask) | (wdata & wmask);
                REG_DIR:  dir_d  = (dir_q  & ~wmask) | (wdata & wmask);
                REG_IEN:  ien_d  = (ien_q  & ~wmask) | (wdata & wmask);
                REG_PEND: clr    = wdata & wmask;
                REG_EDGE: edge_d = (edge_q & ~wmask) | (wdata & wmask);
                default:  ;
            endcase
        end

        // OR-ing the event after the clear makes a coincident set win.
        pend_d = (pend_q & ~clr) | evt;

        rd_word = '0;
        case (reg_sel)
            REG_OUT:  rd_word[N_GPIO-1:0] = out_q;
            REG_DIR:  rd_word[N_GPIO-1:0] = dir_q;
            REG_IN:   rd_word[N_GPIO-1:0] = pin_in;
            REG_IEN:  rd_word[N_GPIO-1:0] = ien_q;
            REG_PEND: rd_word[N_GPIO-1:0] = pend_q;
            REG_EDGE: rd_word[N_GPIO-1:0] = edge_q;
            default:  rd_word = '0;
        endcase

        dat_d = rd ? rd_word : dat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            dir_q  <= '0;
            ien_q  <= '0;
            pend_q <= '0;
            edge_q <= '0;
            prev_q <= '0;
            ack_q  <= 1'b0;
            irq_q  <= 1'b0;
            dat_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ien_q  <= ien_d;
            pend_q <= pend_d;
            edge_q <= edge_d;
            prev_q <= pin_in;
            ack_q  <= req;
            irq_q  <= |(pend_q & ien_q);
            dat_q  <= dat_d;
            sync_q[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign o_gpio   = out_q;
    assign en_gpio  = ~dir_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign o_irq    = irq_q;

endmodule
